// File: rtl/io_bus_arbiter_if.sv
// Signal bundle between the two requesters (CPU = 0, DMA = 1), the arbiter and the IO register file.
// slave: arbiter side; master: requesters plus register-file side.
interface io_bus_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [23:0] addr0;
    logic [23:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [1:0]  width0;
    logic [1:0]  width1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic [23:0] io_addr;
    logic [31:0] io_data_in;
    logic [1:0]  io_width;
    logic        io_read;
    logic        io_write;
    logic [31:0] io_data_out;
    logic        busy;
    logic        grant_id;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, width0, width1, io_data_out,
        output ack0, ack1, rdata0, rdata1, io_addr, io_data_in, io_width, io_read, io_write,
               busy, grant_id
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, width0, width1, io_data_out,
        input  ack0, ack1, rdata0, rdata1, io_addr, io_data_in, io_width, io_read, io_write,
               busy, grant_id
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-port arbiter onto the IO register port; fixed priority + starvation guard, round-robin with IO_ARB_RR_EN.
// Latency: request sampled in IDLE at N, strobe at N+1, ack at N+2; one access per 3 cycles.
// Backpressure: requesters hold req until their ack pulse; the losing port simply waits in IDLE.
module io_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_mem,
    input  logic            rst,
    io_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state_q, state_d;
    logic        grant_vld;
    logic        win;
    logic        we_q, we_d;
    logic        grant_q, grant_d;
    logic [23:0] io_addr_q, io_addr_d;
    logic [31:0] io_data_in_q, io_data_in_d;
    logic [1:0]  io_width_q, io_width_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        io_read, io_write, ack0, ack1, busy;

    assign grant_vld = (state_q == IDLE) && (bus.req0 || bus.req1);

`ifdef IO_ARB_RR_EN
    logic rr_last_q, rr_last_d;

    always_comb begin
        win = bus.req1;
        if (bus.req0 && bus.req1) win = ~rr_last_q;
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (grant_vld) rr_last_d = win;
    end

    always_ff @(posedge clk_mem) begin
        if (rst) rr_last_q <= 1'b1;
        else     rr_last_q <= rr_last_d;
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign win = bus.req1 && (!bus.req0 || (starve_cnt_q == LIMIT));

    // Counts port-0 wins over a waiting port 1; any gap in req1 forgives the streak.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!bus.req1 || (grant_vld && win))
                starve_cnt_d = '0;
            else if (grant_vld && (starve_cnt_q != LIMIT))
                starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_mem) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`endif

    always_ff @(posedge clk_mem) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack is masked by rst so a reset landing in RESP drops the completion.
    always_comb begin
        io_read  = 1'b0;
        io_write = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ISSUE: begin
                busy     = 1'b1;
                io_read  = ~we_q;
                io_write = we_q;
            end
            RESP: begin
                busy = 1'b1;
                ack0 = ~rst & ~grant_q;
                ack1 = ~rst & grant_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        we_d         = we_q;
        grant_d      = grant_q;
        io_addr_d    = io_addr_q;
        io_data_in_d = io_data_in_q;
        io_width_d   = io_width_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        if (grant_vld) begin
            grant_d      = win;
            we_d         = win ? bus.we1    : bus.we0;
            io_addr_d    = win ? bus.addr1  : bus.addr0;
            io_data_in_d = win ? bus.wdata1 : bus.wdata0;
            io_width_d   = win ? bus.width1 : bus.width0;
        end
        if ((state_q == ISSUE) && !we_q) begin
            if (grant_q) rdata1_d = bus.io_data_out;
            else         rdata0_d = bus.io_data_out;
        end
    end

    always_ff @(posedge clk_mem) begin
        if (rst) begin
            we_q         <= 1'b0;
            grant_q      <= 1'b0;
            io_addr_q    <= '0;
            io_data_in_q <= '0;
            io_width_q   <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            we_q         <= we_d;
            grant_q      <= grant_d;
            io_addr_q    <= io_addr_d;
            io_data_in_q <= io_data_in_d;
            io_width_q   <= io_width_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign bus.io_read    = io_read;
    assign bus.io_write   = io_write;
    assign bus.ack0       = ack0;
    assign bus.ack1       = ack1;
    assign bus.busy       = busy;
    assign bus.grant_id   = grant_q;
    assign bus.io_addr    = io_addr_q;
    assign bus.io_data_in = io_data_in_q;
    assign bus.io_width   = io_width_q;
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_io_bus_arbiter;
    localparam int LIMIT = 4;

    logic clk_mem = 1'b0;
    logic rst;
    always #5 clk_mem = ~clk_mem;

    io_bus_arbiter_if bus();

    io_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_mem(clk_mem),
        .rst    (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant at cycle s owns the bus for cycles s+1 (strobe) and s+2 (ack).
    int          cyc = 0;
    bit          m_valid = 0;
    bit          m_tx = 0;
    int          m_s = 0;
    bit          m_we = 0;
    bit          m_grant = 0;
    logic [23:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [1:0]  m_width = '0;
    logic [31:0] m_rdata [2];
    int          m_streak = 0;
    bit          m_rr_last = 1;

    task automatic model_step();
        int c;
        bit w;
        c = cyc;
        if (rst) begin
            m_valid = 1; m_tx = 0; m_we = 0; m_grant = 0;
            m_addr = '0; m_wdata = '0; m_width = '0;
            m_rdata[0] = '0; m_rdata[1] = '0;
            m_streak = 0; m_rr_last = 1;
        end else if (m_valid) begin
            if (m_tx && c == m_s + 1 && !m_we) m_rdata[m_grant] = bus.io_data_out;
            if (!m_tx || c >= m_s + 3) begin
                if (!bus.req1) m_streak = 0;
                if (bus.req0 || bus.req1) begin
`ifdef IO_ARB_RR_EN
                    w = (bus.req0 && bus.req1) ? !m_rr_last : bus.req1;
                    m_rr_last = w;
`else
                    w = bus.req1 && (!bus.req0 || m_streak >= LIMIT);
                    if (w) m_streak = 0;
                    else if (bus.req1) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
`endif
                    m_tx = 1; m_s = c; m_grant = w;
                    m_we    = w ? bus.we1    : bus.we0;
                    m_addr  = w ? bus.addr1  : bus.addr0;
                    m_wdata = w ? bus.wdata1 : bus.wdata0;
                    m_width = w ? bus.width1 : bus.width0;
                end
            end
        end
        cyc = cyc + 1;
    endtask

    task automatic compare();
        int c;
        bit act, strobe, ack;
        c = cyc;
        if (!m_valid) return;
        act    = m_tx && (c == m_s + 1 || c == m_s + 2);
        strobe = m_tx && (c == m_s + 1);
        ack    = m_tx && (c == m_s + 2) && !rst;
        chk("busy",       bus.busy,        act);
        chk("io_read",    bus.io_read,     strobe && !m_we);
        chk("io_write",   bus.io_write,    strobe && m_we);
        chk("ack0",       bus.ack0,        ack && !m_grant);
        chk("ack1",       bus.ack1,        ack && m_grant);
        chk("ack_excl",   bus.ack0 & bus.ack1, 0);
        chk("io_addr",    bus.io_addr,     m_addr);
        chk("io_data_in", bus.io_data_in,  m_wdata);
        chk("io_width",   bus.io_width,    m_width);
        chk("grant_id",   bus.grant_id,    m_grant);
        chk("rdata0",     bus.rdata0,      m_rdata[0]);
        chk("rdata1",     bus.rdata1,      m_rdata[1]);
    endtask

    initial forever begin
        @(posedge clk_mem);
        model_step();
    end

    initial forever begin
        @(negedge clk_mem);
        #2;
        compare();
    end

    task automatic new_req(input bit p);
        if (p) begin
            bus.req1 = 1; bus.we1 = 1'($urandom_range(0, 1)); bus.addr1 = 24'($urandom);
            bus.wdata1 = $urandom; bus.width1 = 2'($urandom);
        end else begin
            bus.req0 = 1; bus.we0 = 1'($urandom_range(0, 1)); bus.addr0 = 24'($urandom);
            bus.wdata0 = $urandom; bus.width0 = 2'($urandom);
        end
    endtask

    task automatic agent(input bit p);
        bit req, ack;
        req = p ? bus.req1 : bus.req0;
        ack = p ? bus.ack1 : bus.ack0;
        if (req && ack) begin
            if ($urandom_range(0, 1) == 1) new_req(p);
            else if (p) bus.req1 = 0;
            else bus.req0 = 0;
        end else if (!req) begin
            new_req(p);
            if ($urandom_range(0, 2) != 0) begin
                if (p) bus.req1 = 0;
                else bus.req0 = 0;
            end
        end
    endtask

    task automatic wait_ack(input bit p, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_mem);
            seen = p ? bus.ack1 : bus.ack0;
        end
        chk(name, seen, 1);
    endtask

    int got[$];

    initial begin
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.width0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.width1 = '0;
        bus.io_data_out = '0;
        rst = 1;
        repeat (3) @(negedge clk_mem);
        rst = 0;
        @(negedge clk_mem); #3;
        chk("rst_busy",    bus.busy,     0);
        chk("rst_ack0",    bus.ack0,     0);
        chk("rst_grant",   bus.grant_id, 0);
        chk("rst_io_addr", bus.io_addr,  0);
        chk("rst_rdata1",  bus.rdata1,   0);

        // Port-0 half-word write.
        @(negedge clk_mem);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 24'h000000; bus.wdata0 = 32'h403; bus.width0 = 2'b01;
        @(negedge clk_mem); #3;
        chk("t1_write",      bus.io_write,   1);
        chk("t1_addr",       bus.io_addr,    0);
        chk("t1_data",       bus.io_data_in, 32'h403);
        chk("t1_width",      bus.io_width,   2'b01);
        chk("t1_ack0_early", bus.ack0,       0);
        @(negedge clk_mem); bus.req0 = 0; #3;
        chk("t1_ack0",       bus.ack0,       1);
        chk("t1_ack1",       bus.ack1,       0);
        chk("t1_write_once", bus.io_write,   0);

        // Port-1 word read.
        @(negedge clk_mem);
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 24'h000130; bus.width1 = 2'b10;
        bus.io_data_out = 32'h000003FF;
        @(negedge clk_mem); #3;
        chk("t2_read",   bus.io_read, 1);
        chk("t2_addr",   bus.io_addr, 24'h000130);
        @(negedge clk_mem); bus.req1 = 0; #3;
        chk("t2_ack1",   bus.ack1,   1);
        chk("t2_rdata1", bus.rdata1, 32'h000003FF);
        chk("t2_rdata0", bus.rdata0, 0);

        // Port-1 write must leave the earlier read data in place.
        @(negedge clk_mem);
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 24'h000400; bus.wdata1 = 32'hCAFE0001;
        bus.io_data_out = 32'h12345678;
        @(negedge clk_mem); #3;
        chk("t6_write", bus.io_write,   1);
        chk("t6_data",  bus.io_data_in, 32'hCAFE0001);
        @(negedge clk_mem); bus.req1 = 0; #3;
        chk("t6_ack1",       bus.ack1,   1);
        chk("t6_rdata1_kept", bus.rdata1, 32'h000003FF);

        // Both ports requesting continuously.
        @(negedge clk_mem);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 24'h000010; bus.wdata0 = 32'h11;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 24'h000020;
        got.delete();
        for (int i = 0; i < 80 && got.size() < 10; i++) begin
            @(negedge clk_mem);
            if (bus.ack0) got.push_back(0);
            if (bus.ack1) got.push_back(1);
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("t3_grants", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++) begin
`ifdef IO_ARB_RR_EN
            chk("t3_seq", got[i], i % 2);
`else
            chk("t3_seq", got[i], (i % 5 == 4) ? 1 : 0);
`endif
        end

        // Reset in the ISSUE cycle of a port-0 write.
        @(negedge clk_mem);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 24'h000055; bus.wdata0 = 32'hA5A5; bus.width0 = 2'b11;
        @(negedge clk_mem); #3;
        chk("t5_write", bus.io_write, 1);
        rst = 1;
        @(negedge clk_mem); rst = 0; bus.req0 = 0; #3;
        chk("t5_busy",    bus.busy,       0);
        chk("t5_ack0",    bus.ack0,       0);
        chk("t5_write0",  bus.io_write,   0);
        chk("t5_io_addr", bus.io_addr,    0);
        chk("t5_io_data", bus.io_data_in, 0);
        chk("t5_rdata1",  bus.rdata1,     0);
        chk("t5_grant",   bus.grant_id,   0);
        @(negedge clk_mem);
        bus.req0 = 1;
        wait_ack(0, "t5_fresh_ack0");
        bus.req0 = 0;

        // Reset in RESP drops the ack.
        @(negedge clk_mem);
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 24'h000077; bus.io_data_out = 32'hBEEF;
        @(negedge clk_mem);
        @(negedge clk_mem); rst = 1; #3;
        chk("t7_ack1_dropped", bus.ack1, 0);
        @(negedge clk_mem); rst = 0; bus.req1 = 0;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_mem);
            bus.io_data_out = $urandom;
            agent(0);
            agent(1);
        end
        bus.req0 = 0; bus.req1 = 0;
        repeat (4) @(negedge clk_mem);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
